i2c_master_arbiter: RTL and testbench

- Shares one `i2c_master` (ADDR_BYTES=1, DATA_BYTES=2) between NUM_REQ requesters using round-robin arbitration.
- Latches the winning request, sequences the master's one-cycle `write_en` / `read_en` strobe, and tracks `busy` / `done` to completion.
- Returns the read data, status and a one-cycle response to the granted requester.
- Timeout counters guarantee forward progress if the master or bus hangs.

---
 rtl/i2c_master_arbiter.sv | 145 ++++++++++++++
 tb/tb_i2c_master_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_arbiter.sv
// rtl/i2c_master_arbiter.sv - round-robin arbiter sharing one I2C master between requesters
module i2c_master_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 16,
    parameter int XFER_TIMEOUT  = 65535
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_rw,
    input  logic [NUM_REQ-1:0]     req_write_mode,
    input  logic [7*NUM_REQ-1:0]   req_chip_addr,
    input  logic [8*NUM_REQ-1:0]   req_reg_addr,
    input  logic [16*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic [15:0]            resp_data,
    output logic [3:0]             resp_status,
    output logic                   resp_error,
    output logic                   busy,
    output logic [6:0]             master_chip_addr,
    output logic [7:0]             master_reg_addr,
    output logic [15:0]            master_data_in,
    output logic                   master_write_mode,
    output logic                   master_write_en,
    output logic                   master_read_en,
    input  logic                   master_busy,
    input  logic                   master_done,
    input  logic [3:0]             master_status,
    input  logic [15:0]            master_data_out
);

    localparam int              PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PW:0]     NREQ      = (PW+1)'(NUM_REQ);
    localparam logic [PW-1:0]   LAST      = PW'(NUM_REQ-1);
    localparam logic [15:0]     START_LIM = 16'(START_TIMEOUT);
    localparam logic [15:0]     XFER_LIM  = 16'(XFER_TIMEOUT);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LAUNCH    = 3'd1;
    localparam logic [2:0] WAIT_BUSY = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] RESP      = 3'd4;

    logic [2:0]    state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] gnt_q;
    logic          rw_q;
    logic [15:0]   cnt;
    logic          error;

    logic          gnt_found;
    logic [PW-1:0] gnt_idx;
    logic [PW:0]   scan;

    // First pending requester at or after rr_ptr, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_ptr} + (PW+1)'(k);
            if (scan >= NREQ)
                scan = scan - NREQ;
            if (!gnt_found && req_valid[scan[PW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan[PW-1:0];
            end
        end
    end

    assign req_ready       = (state == IDLE && gnt_found && !reset) ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign resp_valid      = (state == RESP) ? (NUM_REQ'(1) << gnt_q) : '0;
    assign resp_error      = error;
    assign busy            = (state != IDLE);
    assign master_write_en = (state == LAUNCH) && !rw_q;
    assign master_read_en  = (state == LAUNCH) && rw_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            rr_ptr            <= '0;
            gnt_q             <= '0;
            rw_q              <= 1'b0;
            cnt               <= '0;
            error             <= 1'b0;
            resp_data         <= '0;
            resp_status       <= '0;
            master_chip_addr  <= '0;
            master_reg_addr   <= '0;
            master_data_in    <= '0;
            master_write_mode <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        gnt_q             <= gnt_idx;
                        rw_q              <= req_rw[gnt_idx];
                        master_write_mode <= req_write_mode[gnt_idx];
                        master_chip_addr  <= req_chip_addr[7*int'(gnt_idx) +: 7];
                        master_reg_addr   <= req_reg_addr[8*int'(gnt_idx) +: 8];
                        master_data_in    <= req_data[16*int'(gnt_idx) +: 16];
                        rr_ptr            <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
                        state             <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    cnt   <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // master_done is deliberately ignored here: it may be left over from the last transfer.
                    if (master_busy) begin
                        cnt   <= '0;
                        state <= WAIT_DONE;
                    end else if (cnt >= START_LIM) begin
                        error <= 1'b1;
                        state <= RESP;
                    end else begin
                        cnt <= (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
                    end
                end
                WAIT_DONE: begin
                    if (master_done || !master_busy) begin
                        resp_status <= master_status;
                        if (rw_q)
                            resp_data <= master_data_out;
                        state <= RESP;
                    end else if (cnt >= XFER_LIM) begin
                        error <= 1'b1;
                        state <= RESP;
                    end else begin
                        cnt <= (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
                    end
                end
                RESP: begin
                    error <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb/tb_i2c_master_arbiter.sv - directed self-checking bench for i2c_master_arbiter
module tb_i2c_master_arbiter;

    localparam int NR = 4;
    localparam int ST = 16;
    localparam int XT = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [3:0]    req_valid, req_rw, req_write_mode;
    logic [27:0]   req_chip_addr;
    logic [31:0]   req_reg_addr;
    logic [63:0]   req_data;
    logic [3:0]    req_ready, resp_valid;
    logic [15:0]   resp_data;
    logic [3:0]    resp_status;
    logic          resp_error, busy;
    logic [6:0]    master_chip_addr;
    logic [7:0]    master_reg_addr;
    logic [15:0]   master_data_in;
    logic          master_write_mode, master_write_en, master_read_en;
    logic          master_busy, master_done;
    logic [3:0]    master_status;
    logic [15:0]   master_data_out;

    int vectors = 0;
    int fails   = 0;

    i2c_master_arbiter #(.NUM_REQ(NR), .START_TIMEOUT(ST), .XFER_TIMEOUT(XT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_rw(req_rw), .req_write_mode(req_write_mode),
        .req_chip_addr(req_chip_addr), .req_reg_addr(req_reg_addr), .req_data(req_data),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_status(resp_status), .resp_error(resp_error), .busy(busy),
        .master_chip_addr(master_chip_addr), .master_reg_addr(master_reg_addr),
        .master_data_in(master_data_in), .master_write_mode(master_write_mode),
        .master_write_en(master_write_en), .master_read_en(master_read_en),
        .master_busy(master_busy), .master_done(master_done),
        .master_status(master_status), .master_data_out(master_data_out)
    );

    // Master/slave model: mode 0 normal, 1 busy never rises, 2 busy sticks high.
    int          m_mode = 0;
    int          m_cnt;
    logic        m_rd;
    logic [7:0]  m_reg;
    logic [15:0] m_wd;
    logic [15:0] mem [256];
    int          wr_pulses = 0;
    int          rd_pulses = 0;

    always @(posedge clk) begin
        master_done <= 1'b0;
        if (reset) begin
            m_cnt       <= 0;
            master_busy <= 1'b0;
        end else if (m_mode == 1) begin
            m_cnt       <= 0;
            master_busy <= 1'b0;
        end else if (m_mode == 2) begin
            master_busy     <= master_busy | master_write_en | master_read_en;
            master_status   <= 4'hE;
            master_data_out <= 16'hDEAD;
        end else if (m_cnt == 0) begin
            master_busy <= 1'b0;
            if (master_write_en || master_read_en) begin
                m_cnt <= 1;
                m_rd  <= master_read_en;
                m_reg <= master_reg_addr;
                m_wd  <= master_data_in;
            end
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 2)
                master_busy <= 1'b1;
            if (m_cnt == 6) begin
                master_busy   <= 1'b0;
                master_done   <= 1'b1;
                master_status <= 4'h3;
                if (m_rd)
                    master_data_out <= mem[m_reg];
                else
                    mem[m_reg] <= m_wd;
                m_cnt <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (master_write_en) wr_pulses++;
        if (master_read_en)  rd_pulses++;
    end

    task automatic put_req(input int i, input logic rw, input logic wm, input logic [6:0] ca,
                           input logic [7:0] ra, input logic [15:0] d);
        req_rw[i]                 = rw;
        req_write_mode[i]         = wm;
        req_chip_addr[7*i +: 7]   = ca;
        req_reg_addr[8*i +: 8]    = ra;
        req_data[16*i +: 16]      = d;
        req_valid[i]              = 1'b1;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (resp_valid === 4'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        #1;
        vectors++;
        if (req_ready !== 4'b0)
            begin fails++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        vectors++;
        if ({resp_valid, resp_data, resp_status, resp_error, busy, master_chip_addr, master_reg_addr,
             master_data_in, master_write_mode, master_write_en, master_read_en} !== 63'b0)
            begin fails++; $display("FAIL reset_outputs: got nonzero output, busy=%b resp_valid=%b", busy, resp_valid); end
        req_valid = 4'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0)
            begin fails++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single_write();
        int n;
        int w0;
        w0 = wr_pulses;
        put_req(0, 1'b0, 1'b1, 7'h0F, 8'h0A, 16'hB2B2);
        #1;
        vectors++;
        if (req_ready !== 4'b0001)
            begin fails++; $display("FAIL write_req_ready: got %b expected 0001", req_ready); end
        @(negedge clk);
        req_valid[0] = 1'b0;
        vectors++;
        if ({busy, master_write_en, master_read_en} !== 3'b110)
            begin fails++; $display("FAIL write_strobe: got busy/wr/rd %b expected 110", {busy, master_write_en, master_read_en}); end
        vectors++;
        if ({master_chip_addr, master_reg_addr, master_data_in, master_write_mode} !== {7'h0F, 8'h0A, 16'hB2B2, 1'b1})
            begin fails++; $display("FAIL write_fields: got %h/%h/%h/%b expected 0f/0a/b2b2/1",
                                    master_chip_addr, master_reg_addr, master_data_in, master_write_mode); end
        wait_resp(n);
        vectors++;
        if ({resp_valid, resp_error} !== 5'b00010)
            begin fails++; $display("FAIL write_resp: got valid=%b err=%b expected 0001/0", resp_valid, resp_error); end
        @(negedge clk);
        vectors++;
        if ({resp_valid, busy} !== 5'b0)
            begin fails++; $display("FAIL write_after_resp: got valid=%b busy=%b expected 0000/0", resp_valid, busy); end
        vectors++;
        if (wr_pulses - w0 !== 1)
            begin fails++; $display("FAIL write_pulse_count: got %0d expected 1", wr_pulses - w0); end
        vectors++;
        if (mem[8'h0A] !== 16'hB2B2)
            begin fails++; $display("FAIL write_slave_mem: got %h expected b2b2", mem[8'h0A]); end
    endtask

    task automatic test_single_read();
        int n;
        put_req(2, 1'b1, 1'b0, 7'h0F, 8'h0A, 16'h0000);
        #1;
        vectors++;
        if (req_ready !== 4'b0100)
            begin fails++; $display("FAIL read_req_ready: got %b expected 0100", req_ready); end
        @(negedge clk);
        req_valid[2] = 1'b0;
        vectors++;
        if ({master_write_en, master_read_en} !== 2'b01)
            begin fails++; $display("FAIL read_strobe: got wr/rd %b expected 01", {master_write_en, master_read_en}); end
        wait_resp(n);
        vectors++;
        if ({resp_valid, resp_error, resp_data, resp_status} !== {4'b0100, 1'b0, 16'hB2B2, 4'h3})
            begin fails++; $display("FAIL read_resp: got valid=%b err=%b data=%h status=%h expected 0100/0/b2b2/3",
                                    resp_valid, resp_error, resp_data, resp_status); end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [3:0] grants [4];
        logic [3:0] exp_g  [4];
        int got;
        int cyc;
        int n;
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b1000; exp_g[3] = 4'b0001;
        for (int i = 0; i < 4; i++) grants[i] = 4'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        put_req(0, 1'b0, 1'b0, 7'h11, 8'h10, 16'h1000);
        put_req(1, 1'b0, 1'b0, 7'h11, 8'h11, 16'h1111);
        put_req(3, 1'b0, 1'b0, 7'h11, 8'h13, 16'h3333);
        got = 0;
        cyc = 0;
        while (got < 4 && cyc < 400) begin
            #1;
            if (req_ready !== 4'b0) begin
                grants[got] = req_ready;
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = 4'b0;
        vectors++;
        if (got !== 4)
            begin fails++; $display("FAIL rr_grant_count: got %0d expected 4", got); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (grants[i] !== exp_g[i])
                begin fails++; $display("FAIL rr_grant%0d: got %b expected %b", i, grants[i], exp_g[i]); end
        end
        wait_resp(n);
        @(negedge clk);
        vectors++;
        if ({mem[8'h11], mem[8'h13]} !== {16'h1111, 16'h3333})
            begin fails++; $display("FAIL rr_slave_mem: got %h %h expected 1111 3333", mem[8'h11], mem[8'h13]); end
    endtask

    task automatic test_start_timeout();
        int n;
        m_mode = 1;
        put_req(1, 1'b0, 1'b0, 7'h0F, 8'h30, 16'h5555);
        #1;
        vectors++;
        if (req_ready !== 4'b0010)
            begin fails++; $display("FAIL start_to_req_ready: got %b expected 0010", req_ready); end
        @(negedge clk);
        req_valid[1] = 1'b0;
        wait_resp(n);
        vectors++;
        if (n !== ST + 2)
            begin fails++; $display("FAIL start_to_latency: got %0d expected %0d", n, ST + 2); end
        vectors++;
        if ({resp_valid, resp_error} !== 5'b00101)
            begin fails++; $display("FAIL start_to_resp: got valid=%b err=%b expected 0010/1", resp_valid, resp_error); end
        @(negedge clk);
        vectors++;
        if ({resp_valid, resp_error} !== 5'b0)
            begin fails++; $display("FAIL start_to_clear: got valid=%b err=%b expected 0000/0", resp_valid, resp_error); end
        m_mode = 0;
        put_req(2, 1'b1, 1'b0, 7'h0F, 8'h0A, 16'h0000);
        #1;
        vectors++;
        if (req_ready !== 4'b0100)
            begin fails++; $display("FAIL start_to_next_ready: got %b expected 0100", req_ready); end
        @(negedge clk);
        req_valid[2] = 1'b0;
        wait_resp(n);
        vectors++;
        if ({resp_valid, resp_error, resp_data, resp_status} !== {4'b0100, 1'b0, 16'hB2B2, 4'h3})
            begin fails++; $display("FAIL start_to_next_resp: got valid=%b err=%b data=%h status=%h expected 0100/0/b2b2/3",
                                    resp_valid, resp_error, resp_data, resp_status); end
        @(negedge clk);
    endtask

    task automatic test_hung_transfer();
        int n;
        m_mode = 2;
        put_req(3, 1'b0, 1'b0, 7'h0F, 8'h40, 16'h7777);
        #1;
        vectors++;
        if (req_ready !== 4'b1000)
            begin fails++; $display("FAIL hung_req_ready: got %b expected 1000", req_ready); end
        @(negedge clk);
        req_valid[3] = 1'b0;
        wait_resp(n);
        vectors++;
        if (n !== XT + 3)
            begin fails++; $display("FAIL hung_latency: got %0d expected %0d", n, XT + 3); end
        vectors++;
        if ({resp_valid, resp_error} !== 5'b10001)
            begin fails++; $display("FAIL hung_resp: got valid=%b err=%b expected 1000/1", resp_valid, resp_error); end
        vectors++;
        if ({resp_data, resp_status} !== {16'hB2B2, 4'h3})
            begin fails++; $display("FAIL hung_hold: got data=%h status=%h expected b2b2/3", resp_data, resp_status); end
        @(negedge clk);
        m_mode = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_transfer();
        int n;
        int stray;
        put_req(0, 1'b0, 1'b0, 7'h0F, 8'h50, 16'hAAAA);
        @(negedge clk);
        req_valid[0] = 1'b0;
        n = 0;
        while (master_busy !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (master_busy !== 1'b1)
            begin fails++; $display("FAIL mid_busy_timeout: got master_busy %b expected 1", master_busy); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busy, resp_valid, master_write_en, master_read_en} !== 7'b0)
            begin fails++; $display("FAIL mid_reset_state: got busy=%b valid=%b wr=%b rd=%b expected all 0",
                                    busy, resp_valid, master_write_en, master_read_en); end
        reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (resp_valid !== 4'b0) stray++;
        end
        vectors++;
        if (stray !== 0)
            begin fails++; $display("FAIL mid_stray_resp: got %0d resp cycles expected 0", stray); end
        put_req(0, 1'b0, 1'b0, 7'h0F, 8'h60, 16'h1234);
        put_req(3, 1'b0, 1'b0, 7'h0F, 8'h63, 16'h9999);
        #1;
        vectors++;
        if (req_ready !== 4'b0001)
            begin fails++; $display("FAIL mid_rr_ptr: got %b expected 0001", req_ready); end
        @(negedge clk);
        req_valid = 4'b0;
        wait_resp(n);
        vectors++;
        if ({resp_valid, resp_error} !== 5'b00010)
            begin fails++; $display("FAIL mid_next_resp: got valid=%b err=%b expected 0001/0", resp_valid, resp_error); end
        @(negedge clk);
        vectors++;
        if (mem[8'h60] !== 16'h1234)
            begin fails++; $display("FAIL mid_slave_mem: got %h expected 1234", mem[8'h60]); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        reset          = 1'b1;
        req_valid      = 4'b0;
        req_rw         = 4'b0;
        req_write_mode = 4'b0;
        req_chip_addr  = '0;
        req_reg_addr   = '0;
        req_data       = '0;
        master_status   = 4'h0;
        master_data_out = 16'h0;
        test_reset();
        test_single_write();
        test_single_read();
        test_round_robin();
        test_start_timeout();
        test_hung_transfer();
        test_reset_mid_transfer();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
